// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int unsigned ZERO_REG      = 0;
  localparam int unsigned DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and pipeline-register controls back to the datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_clr;
  logic             id_ex_we;
  logic             id_ex_clr;
  logic             ex_mem_we;
  logic             mem_wb_clr;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           ex_branch_taken, mem_req, dmem_ready,
    input  pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr,
           mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           ex_branch_taken, mem_req, dmem_ready,
    output pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr,
           mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX feeds a register read in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             hit
);

  always_comb begin
    hit = ex_mem_read && (ex_rt != REG_W'(ZERO_REG)) &&
          ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes and bubbles for the 5-stage core, with a
// memory-wait timeout and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W,
  parameter int unsigned MAX_WAIT = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic lu_hit;
  logic freeze, resolve, halt, flush;
  logic pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .hit         (lu_hit)
  );

  assign wait_inc = wait_q + WAIT_W'(1);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    resolve   = 1'b0;
    halt      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.dmem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          freeze = 1'b1;
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(MAX_WAIT)) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end
        end else begin
          resolve = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end
      end
      ERR:     halt = 1'b1;
      default: begin
        halt    = 1'b1;
        state_d = ERR;
      end
    endcase
  end

  // Control outputs: Mealy decode of the current state and hazard inputs.
  always_comb begin
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_we   = 1'b1;
    id_ex_clr  = 1'b0;
    ex_mem_we  = 1'b1;
    mem_wb_clr = 1'b0;
    flush      = 1'b0;
    if (!rst_n || halt) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (freeze) begin
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_ex_we   = 1'b0;
      ex_mem_we  = 1'b0;
      mem_wb_clr = 1'b1;
    end else if (resolve) begin
      if (bus.ex_branch_taken) begin
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
        flush     = 1'b1;
      end else if (lu_hit) begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_clr = 1'b1;
      end else if (bus.id_jump) begin
        if_id_clr = 1'b1;
        flush     = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_we && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush && (flush_q != '1))  flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.if_id_we   = if_id_we;
  assign bus.if_id_clr  = if_id_clr;
  assign bus.id_ex_we   = id_ex_we;
  assign bus.id_ex_clr  = id_ex_clr;
  assign bus.ex_mem_we  = ex_mem_we;
  assign bus.mem_wb_clr = mem_wb_clr;
  assign bus.mem_err    = mem_err_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=3, MAX_WAIT=4).
module tb_pipeline_hazard_ctrl;

  // {pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr}
  localparam logic [6:0] C_DEF    = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_JUMP   = 7'b1111010;
  localparam logic [6:0] C_ZERO   = 7'b0000000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(3)) bus ();

  pipeline_hazard_ctrl #(
    .REG_W    (5),
    .CNT_W    (3),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] ctl;
  assign ctl = {bus.pc_we, bus.if_id_we, bus.if_id_clr, bus.id_ex_we, bus.id_ex_clr,
                bus.ex_mem_we, bus.mem_wb_clr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.id_jump         = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rt           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.dmem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ZERO) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_ZERO);
    end
    n_checks++;
    if (bus.stall_cnt !== 3'd0 || bus.flush_cnt !== 3'd0 || bus.mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b want 0 0 0",
               bus.stall_cnt, bus.flush_cnt, bus.mem_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_DEF) begin
      n_fail++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_DEF);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      n_fail++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, C_LU);
    end
    @(negedge clk);
    bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
    #1;
    n_checks++;
    if (bus.stall_cnt !== 3'd1) begin
      n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt);
    end
    n_checks++;
    if (ctl !== C_DEF) begin
      n_fail++; $display("FAIL lu_zero_reg: got %b want %b", ctl, C_DEF);
    end
    @(negedge clk);
    bus.ex_rt = 5'd8; bus.id_rs = 5'd3; bus.id_rt = 5'd8; bus.id_uses_rt = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_DEF) begin
      n_fail++; $display("FAIL lu_rt_unused: got %b want %b", ctl, C_DEF);
    end
    @(negedge clk);
    bus.id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      n_fail++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, C_LU);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (bus.stall_cnt !== 3'd2 || bus.flush_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL lu_counts: got stall=%0d flush=%0d want 2 0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    @(negedge clk);
    bus.ex_branch_taken = 1'b1; bus.id_jump = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9; bus.id_uses_rs = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_BRANCH) begin
      n_fail++; $display("FAIL br_lu_ctl: got %b want %b", ctl, C_BRANCH);
    end
    @(negedge clk);
    set_idle();
    bus.id_jump = 1'b1;
    #1;
    n_checks++;
    if (bus.flush_cnt !== 3'd1 || bus.stall_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL br_counts: got flush=%0d stall=%0d want 1 0", bus.flush_cnt, bus.stall_cnt);
    end
    n_checks++;
    if (ctl !== C_JUMP) begin
      n_fail++; $display("FAIL jump_ctl: got %b want %b", ctl, C_JUMP);
    end
    @(negedge clk);
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rt = 5'd4; bus.id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      n_fail++; $display("FAIL jump_lu_ctl: got %b want %b", ctl, C_LU);
    end
    @(negedge clk);
    bus.ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_JUMP || bus.flush_cnt !== 3'd2 || bus.stall_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL jump_retry: got ctl=%b flush=%0d stall=%0d want %b 2 1",
               ctl, bus.flush_cnt, bus.stall_cnt, C_JUMP);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (bus.flush_cnt !== 3'd3) begin
      n_fail++; $display("FAIL jump_flush_cnt: got %0d want 3", bus.flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
      bus.ex_branch_taken = (i == 0);
      #1;
      n_checks++;
      if (ctl !== C_FREEZE) begin
        n_fail++; $display("FAIL mw_freeze_%0d: got %b want %b", i, ctl, C_FREEZE);
      end
    end
    @(negedge clk);
    bus.dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_DEF) begin
      n_fail++; $display("FAIL mw_ready_ctl: got %b want %b", ctl, C_DEF);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (ctl !== C_DEF || bus.stall_cnt !== 3'd3 || bus.flush_cnt !== 3'd0 ||
        bus.mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mw_after: got ctl=%b stall=%0d flush=%0d err=%b want %b 3 0 0",
               ctl, bus.stall_cnt, bus.flush_cnt, bus.mem_err, C_DEF);
    end
    bus.mem_req = 1'b1;
    @(negedge clk);
    bus.dmem_ready = 1'b1; bus.ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_BRANCH) begin
      n_fail++; $display("FAIL mw_ready_branch: got %b want %b", ctl, C_BRANCH);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (bus.flush_cnt !== 3'd1 || bus.stall_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL mw_branch_counts: got flush=%0d stall=%0d want 1 4",
               bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
      #1;
      n_checks++;
      if (ctl !== C_FREEZE || bus.mem_err !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait_%0d: got ctl=%b err=%b want %b 0", i, ctl, bus.mem_err, C_FREEZE);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (ctl !== C_ZERO || bus.mem_err !== 1'b1 || bus.stall_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL to_err: got ctl=%b err=%b stall=%0d want %b 1 4",
               ctl, bus.mem_err, bus.stall_cnt, C_ZERO);
    end
    @(negedge clk);
    bus.dmem_ready = 1'b1; bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (ctl !== C_ZERO || bus.mem_err !== 1'b1 || bus.flush_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL to_sticky: got ctl=%b err=%b flush=%0d want %b 1 0",
               ctl, bus.mem_err, bus.flush_cnt, C_ZERO);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (ctl !== C_FREEZE || bus.stall_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL ar_pre: got ctl=%b stall=%0d want %b 1", ctl, bus.stall_cnt, C_FREEZE);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ZERO || bus.stall_cnt !== 3'd0 || bus.flush_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL ar_drop: got ctl=%b stall=%0d flush=%0d want %b 0 0",
               ctl, bus.stall_cnt, bus.flush_cnt, C_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    #1;
    n_checks++;
    if (ctl !== C_DEF) begin
      n_fail++; $display("FAIL ar_release: got %b want %b", ctl, C_DEF);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (ctl !== C_DEF || bus.stall_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL ar_run_state: got ctl=%b stall=%0d want %b 0", ctl, bus.stall_cnt, C_DEF);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd12; bus.id_rs = 5'd12; bus.id_uses_rs = 1'b1;
    repeat (9) @(negedge clk);
    set_idle();
    #1;
    n_checks++;
    if (bus.stall_cnt !== 3'd7) begin
      n_fail++; $display("FAIL sat_stall: got %0d want 7", bus.stall_cnt);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.stall_cnt !== 3'd7 || ctl !== C_DEF) begin
      n_fail++;
      $display("FAIL sat_hold: got stall=%0d ctl=%b want 7 %b", bus.stall_cnt, ctl, C_DEF);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It drives write-enable and clear controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Resolves load-use hazards, taken branches, jumps and multi-cycle data-memory stalls.
- Small FSM with a memory-wait timeout.
- Saturating stall and flush performance counters.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 32, width of performance counters
MAX_WAIT, 255, max consecutive MEM_WAIT cycles before error (≥2)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset: one clock; reset is asynchronous and active-low
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_jump  in  1  J/JAL/JR resolved in ID
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  REG_W  load destination in EX
ex_branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage performing data-memory access
dmem_ready  in  1  data memory completes access this cycle
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID write enable (0 = stall)
if_id_clr  out  1  IF/ID synchronous clear
id_ex_we  out  1  ID/EX write enable
id_ex_clr  out  1  ID/EX synchronous clear (bubble)
ex_mem_we  out  1  EX/MEM write enable
mem_wb_clr  out  1  MEM/WB clear (bubble into WB)
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_we=0
flush_cnt  out  CNT_W  cycles with a control-flow flush

Behaviour:
- States: RUN, MEM_WAIT, ERR. Outputs are Mealy, from state plus current inputs. State, wait counter, mem_err and the two counters are registered.
- Reset (rst_n=0, async): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. All we outputs=0, all clr outputs=0 while rst_n is low.
- Default in RUN: all we=1, all clr=0.
- Priority in RUN, highest first:
  1. Mem stall: mem_req & ~dmem_ready. pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_clr=1. Next state MEM_WAIT, wait_cnt<=1.
  2. Branch: ex_branch_taken. pc_we=1, if_id_clr=1, id_ex_clr=1, giving 2 wrong-path bubbles. A simultaneous jump or load-use is ignored because those instructions are squashed.
  3. Load-use: ex_mem_read & ex_rt≠0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)). pc_we=0, if_id_we=0, id_ex_clr=1. Exactly 1 bubble.
  4. Jump: id_jump. if_id_clr=1, 1 bubble. A jump also hit by load-use waits for the stall to clear and is re-evaluated next cycle.
- IF/ID stall has precedence over clear in the register. The controller never asserts if_id_clr with if_id_we=0.
- MEM_WAIT:
  - ~dmem_ready: freeze outputs as in rule 1; wait_cnt++.
  - wait_cnt reaching MAX_WAIT with ready still low: next state ERR.
  - dmem_ready=1: evaluate RUN priorities 2–4 this same cycle; next state RUN; wait_cnt<=0.
- ERR: all we=0, all clr=0, mem_err=1. Exit only by reset.
- stall_cnt increments on every cycle with rst_n=1 and pc_we=0, including ERR.
- flush_cnt increments on cycles where rule 2 or rule 4 fires.
- Both counters saturate at all-ones; no wrap.
- Register $0 never causes a load-use stall.
- Latency: control outputs are combinational in the same cycle as the hazard inputs.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERR}
  - constant ZERO_REG=0
  - default CNT_W
- One natural sub-module, load_use_detect: purely combinational comparator producing the rule-3 hit. It is instantiated once and also reusable by the forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_clr=1 that cycle; stall_cnt=1. Same with ex_rt=0 -> no stall.
- Branch+load-use simultaneous: ex_branch_taken=1 plus matching load-use -> pc_we=1, if_id_clr=1, id_ex_clr=1, if_id_we=1; flush_cnt+1, stall_cnt unchanged.
- Memory wait: mem_req=1, dmem_ready low 3 cycles then high -> 3 cycles with all we=0 and mem_wb_clr=1; 4th cycle defaults; state back to RUN; stall_cnt=3.
- Timeout: MAX_WAIT=4, mem_req=1, dmem_ready held 0 -> ERR entered after the 4th wait cycle, mem_err=1 sticky even if dmem_ready later=1.
- Async reset mid-MEM_WAIT: drop rst_n between edges -> outputs and counters go 0 immediately; after release, state RUN with default enables.
- Counter saturation: CNT_W=3, force 9 stall cycles -> stall_cnt stays 7.
